gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock, rising-edge active.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: ena  input  1  design enable; 0 freezes all state and outputs.
REQ-004 SHALL provide port: start  input  1  sweep request, sampled only in IDLE.
REQ-005 SHALL provide port: settle  input  2  extra settle cycles per vector (0..3), latched on start acceptance.
REQ-006 SHALL provide port: gate_a  output  1  operand A driven to gate unit.
REQ-007 SHALL provide port: gate_b  output  1  operand B driven to gate unit.
REQ-008 SHALL provide port: gate_y  input  8  gate unit result, bit0..7 = AND, OR, XOR, NAND, NOR, XNOR, NOT A, NOT B.
REQ-009 SHALL provide port: busy  output  1  high in DRIVE and CAPTURE.
REQ-010 SHALL provide port: done  output  1  one-cycle pulse at sweep end.
REQ-011 SHALL provide port: pass  output  1  1 when last sweep had zero mismatches; held until next accepted start.
REQ-012 SHALL provide port: fail_mask  output  4  bit i = vector i mismatched.
REQ-013 SHALL provide port: fail_y  output  8  gate_y XOR expected at first failing vector; 0 if none.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, CAPTURE, DONE.
REQ-015 IDLE: start=1 -> DRIVE with vector index 0; settle latched; fail_mask, fail_y, pass cleared.
REQ-016 Vector i drives gate_a = i[1], gate_b = i[0]; order (A,B) = 00, 01, 10, 11.
REQ-017 DRIVE SHALL last settle+1 cycles, then go to CAPTURE.
REQ-018 CAPTURE (one cycle) SHALL compare gate_y against expected {~B, ~A, ~(A^B), ~(A|B), ~(A&B), A^B, A|B, A&B} and set fail_mask[i] on any mismatch.
REQ-019 fail_y SHALL load the mismatch vector only on the first failing vector of a sweep.
REQ-020 CAPTURE: index<3 -> increment index, go to DRIVE; index=3 -> DONE.
REQ-021 DONE (one cycle): done=1, pass = (fail_mask==0 including this vector's result), then IDLE.
REQ-022 With start accepted at edge T, done SHALL be high in cycle T+1+4*(settle+2).
REQ-023 gate_a, gate_b SHALL be 0 in IDLE and DONE; they change only on DRIVE entry.
REQ-024 start during DRIVE, CAPTURE or DONE SHALL be ignored (no restart, no queueing).
REQ-025 settle changes after acceptance SHALL NOT affect the running sweep.
REQ-026 ena=0 SHALL hold state, counters and all outputs; done, if high, stays high until ena returns and one enabled cycle elapses.
REQ-027 All outputs SHALL be registered; no combinational path from gate_y to any output.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, index 0, settle counter 0, gate_a=0, gate_b=0, busy=0, done=0, pass=0, fail_mask=0, fail_y=0.
REQ-029 Reset mid-sweep SHALL abort without a done pulse; the first start after release SHALL run a full sweep.

Structure
REQ-030 Package gate_sweep_pkg SHALL hold the state enum, NUM_VEC=4, output bit-index constants, and the expected-result function.
REQ-031 One sub-module gate_golden (combinational A,B -> 8-bit expected) SHALL be instantiated; FSM, counters and the compare stay in gate_sweep_ctrl.

Verification
REQ-032 Correct gate model, settle=0, start at T -> done at T+9, pass=1, fail_mask=0000, fail_y=00.
REQ-033 settle=3, correct model -> done at T+21; gate_a/gate_b each vector held 4 cycles.
REQ-034 gate_y[2] stuck-at-0 -> fail_mask=0110, fail_y=8'h04, pass=0.
REQ-035 start re-pulsed while busy -> ignored; done still at T+9; exactly one done pulse.
REQ-036 ena=0 for 5 cycles during vector 1 -> all outputs frozen; done at T+14.
REQ-037 rst_n low during CAPTURE of vector 2 -> all outputs 0 immediately, no done; subsequent start gives done at start+9.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_sweep_pkg                                                       |
// | Shared types, constants and golden gate function for the sweep ctrl. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } sweep_state_t;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int SET_W   = 2;
  localparam int Y_W     = 8;

  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_XOR  = 2;
  localparam int Y_NAND = 3;
  localparam int Y_NOR  = 4;
  localparam int Y_XNOR = 5;
  localparam int Y_NOTA = 6;
  localparam int Y_NOTB = 7;

  function automatic logic [Y_W-1:0] gate_expected(input logic a, input logic b);
    logic [Y_W-1:0] y;
    y         = '0;
    y[Y_AND]  = a & b;
    y[Y_OR]   = a | b;
    y[Y_XOR]  = a ^ b;
    y[Y_NAND] = ~(a & b);
    y[Y_NOR]  = ~(a | b);
    y[Y_XNOR] = ~(a ^ b);
    y[Y_NOTA] = ~a;
    y[Y_NOTB] = ~b;
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_golden.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_golden                                                          |
// | Combinational reference: operands A,B -> expected 8-bit gate result. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module gate_golden
  import gate_sweep_pkg::*;
(
  input  logic           i_a,
  input  logic           i_b,
  output logic [Y_W-1:0] o_y
);

  assign o_y = gate_expected(i_a, i_b);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_sweep_ctrl                                                      |
// | Sweeps A,B through all four vectors and checks the 8-bit gate result.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [SET_W-1:0] settle,
  output logic             gate_a,
  output logic             gate_b,
  input  logic [Y_W-1:0]   gate_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [Y_W-1:0]   fail_y
);

  sweep_state_t     r_state;
  sweep_state_t     w_state_nxt;
  logic [VEC_W-1:0] r_idx;
  logic [SET_W-1:0] r_cnt;
  logic [SET_W-1:0] r_settle;

  logic [Y_W-1:0]   w_expected;
  logic [Y_W-1:0]   w_diff;
  logic             w_mismatch;
  logic             w_drive_end;
  logic             w_last_vec;
  logic [VEC_W-1:0] w_idx_nxt;

  // Golden model is fed from the registered operands, so it matches what the gate unit sees
  gate_golden u_golden (
    .i_a (gate_a),
    .i_b (gate_b),
    .o_y (w_expected)
  );

  assign w_diff      = gate_y ^ w_expected;
  assign w_mismatch  = |w_diff;
  assign w_drive_end = (r_cnt == r_settle);
  assign w_last_vec  = (r_idx == VEC_W'(NUM_VEC - 1));
  assign w_idx_nxt   = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_DRIVE;
      ST_DRIVE:   if (w_drive_end) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = w_last_vec ? ST_DONE : ST_DRIVE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_settle  <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      fail_y    <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_settle  <= settle;
            r_idx     <= '0;
            r_cnt     <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_mask <= '0;
            fail_y    <= '0;
          end
        end
        ST_DRIVE: begin
          r_cnt <= w_drive_end ? '0 : r_cnt + 1'b1;
        end
        ST_CAPTURE: begin
          if (w_mismatch) begin
            fail_mask[r_idx] <= 1'b1;
            // An all-zero mask means no earlier vector of this sweep has failed
            if (fail_mask == '0) fail_y <= w_diff;
          end
          if (w_last_vec) begin
            busy   <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else begin
            r_idx  <= w_idx_nxt;
            gate_a <= w_idx_nxt[1];
            gate_b <= w_idx_nxt[0];
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          pass <= (fail_mask == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gate_sweep_ctrl                                                   |
// | Randomized scoreboard bench with a faulty-gate-unit reference model. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [1:0] settle;
  logic       gate_a, gate_b;
  logic [7:0] gate_y;
  logic       busy, done, pass;
  logic [3:0] fail_mask;
  logic [7:0] fail_y;

  logic [7:0] sa0, sa1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         done_cyc;
    int         busy_cyc;
    logic [3:0] fm;
    logic [7:0] fy;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  gate_sweep_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .settle    (settle),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .gate_y    (gate_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .fail_y    (fail_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Truth table of a healthy gate unit, from arithmetic on 0/1 operands
  function automatic logic [7:0] truth(input int a, input int b);
    logic [7:0] y;
    y[0] = (a * b) != 0;
    y[1] = (a + b) > 0;
    y[2] = ((a + b) % 2) != 0;
    y[3] = (a * b) == 0;
    y[4] = (a + b) == 0;
    y[5] = ((a + b) % 2) == 0;
    y[6] = (a == 0);
    y[7] = (b == 0);
    return y;
  endfunction

  always_comb gate_y = (truth(int'(gate_a), int'(gate_b)) & ~sa0) | sa1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per rising done
  logic prev_done = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("fail_mask", fail_mask, e.fm);
          check("fail_y", fail_y, e.fy);
          check("pass", pass, e.pass);
          check("busy_cycles", busy_cnt, e.busy_cyc);
          check("gates_idle", {gate_a, gate_b, busy}, 3'b000);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {gate_a, gate_b, busy, done, pass, fail_mask, fail_y}, 17'd0);
  endtask

  task automatic run_sweep(input int s, input logic [7:0] f0, input logic [7:0] f1,
                           input int stall_at, input int stall_len, input int rep_at,
                           input bit hold, input bit abort);
    exp_t e;
    bit   got_done;
    int   good, bad;
    @(negedge clk);
    sa0    = f0;
    sa1    = f1 & ~f0;
    settle = 2'(s);
    start  = 1'b1;
    e.fm = '0;
    e.fy = '0;
    for (int v = 0; v < 4; v++) begin
      logic [7:0] d;
      d = truth(v / 2, v % 2) ^ ((truth(v / 2, v % 2) & ~sa0) | sa1);
      if (d != 0) begin
        if (e.fm == 0) e.fy = d;
        e.fm[v] = 1'b1;
      end
    end
    e.pass     = (e.fm == 0);
    e.busy_cyc = 4 * (s + 2) + ((stall_at > 0) ? stall_len : 0);
    e.done_cyc = cyc + 2 + e.busy_cyc;
    if (!abort) sb.push_back(e);
    got_done = 1'b0;
    good = 0; bad = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start  = (n == rep_at);
      settle = 2'($urandom_range(0, 3));
      if (stall_at > 0 && n == stall_at) ena = 1'b0;
      if (stall_at > 0 && n == stall_at + stall_len) ena = 1'b1;
      if (abort && n == 2 * (s + 2) + s + 2) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_abort");
        start = 1'b0;
        ena   = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        break;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!abort) check("done_timeout", got_done, 1'b1);
    if (got_done && hold) begin
      ena = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("done_hold", done, 1'b1);
      end
      ena = 1'b1;
      @(negedge clk);
      check("done_release", done, 1'b0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    settle = 2'd0;
    sa0    = 8'h00;
    sa1    = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    run_sweep(0, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0);   // clean, settle 0
    run_sweep(3, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0);   // clean, settle 3
    run_sweep(0, 8'h04, 8'h00, 0, 0, 0, 1'b0, 1'b0);   // XOR stuck-at-0
    run_sweep(0, 8'h00, 8'h00, 0, 0, 3, 1'b0, 1'b0);   // start re-pulsed while busy
    run_sweep(0, 8'h00, 8'h00, 3, 5, 0, 1'b1, 1'b0);   // ena low during vector 1
    run_sweep(0, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b1);   // reset during vector 2 capture
    run_sweep(0, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0);   // full sweep after abort
    run_sweep(1, 8'h00, 8'h81, 0, 0, 0, 1'b0, 1'b0);   // stuck-at-1 pair

    for (int k = 0; k < 24; k++) begin
      int         s, st_at, st_len, rp;
      logic [7:0] f0, f1;
      s  = $urandom_range(0, 3);
      f0 = ($urandom_range(0, 1) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      f1 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      st_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 * (s + 2)) : 0;
      st_len = $urandom_range(1, 6);
      rp     = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4 * (s + 2)) : 0;
      run_sweep(s, f0, f1, st_at, st_len, rp, ($urandom_range(0, 2) == 0), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
